// File: rtl/spdif_frame_encoder.sv
// S/PDIF frame encoder: biphase-mark serialiser producing B/M/W preambles,
// 24-bit audio, V/U/C/P slots and 192-frame channel-status blocks.
module spdif_frame_encoder #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data_left,
  input  logic [31:0] data_right,
  input  logic        validity,
  input  logic [3:0]  sample_rate_code,
  output logic        sample_req,
  output logic        block_start,
  output logic        busy,
  output logic        spdif_out
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD} state_t;

  localparam int unsigned   DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [7:0]    PRE_B   = 8'b11101000;
  localparam logic [7:0]    PRE_M   = 8'b11100010;
  localparam logic [7:0]    PRE_W   = 8'b11100100;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          strobe;
  logic [5:0]    hc, hc_nxt;            // half-cell index within the subframe
  logic          sub, sub_nxt;          // 0 = left, 1 = right
  logic [7:0]    frame_cnt, frame_cnt_nxt;
  logic [7:0]    pre_pat, pre_pat_nxt;  // preamble already adjusted for line polarity
  logic          out_nxt;
  logic          latch;

  logic [23:0]   hold_left, hold_right;
  logic          hold_valid;
  logic [3:0]    hold_rate;

  logic [4:0]    slot;
  logic [23:0]   sample;
  logic          c_bit, p_bit, slot_bit;
  logic          unused_low;

  assign unused_low = ^{data_left[7:0], data_right[7:0]};

  assign strobe = (div_cnt == DIV_MAX);
  assign busy   = (state != IDLE);

  // Payload bit for the half-cell about to be driven.
  assign slot   = hc_nxt[5:1];
  assign sample = sub ? hold_right : hold_left;
  assign c_bit  = (frame_cnt >= 8'd24 && frame_cnt <= 8'd27) ? hold_rate[frame_cnt[1:0]] : 1'b0;
  assign p_bit  = ^{sample, ~hold_valid, c_bit};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    slot_bit = 1'b0;
    case (slot)
      5'd28:   slot_bit = ~hold_valid;
      5'd29:   slot_bit = 1'b0;
      5'd30:   slot_bit = c_bit;
      5'd31:   slot_bit = p_bit;
      default: slot_bit = sample[slot - 5'd4];
    endcase
  end

  always_comb begin
    state_nxt     = state;
    hc_nxt        = hc;
    sub_nxt       = sub;
    frame_cnt_nxt = frame_cnt;
    pre_pat_nxt   = pre_pat;
    out_nxt       = spdif_out;
    latch         = 1'b0;

    if (strobe) begin
      case (state)
        IDLE: begin
          if (en) begin
            state_nxt     = PREAMBLE;
            hc_nxt        = '0;
            sub_nxt       = 1'b0;
            frame_cnt_nxt = '0;
            latch         = 1'b1;
          end
        end
        default: begin
          if (hc == 6'd63) begin
            hc_nxt    = '0;
            state_nxt = PREAMBLE;
            if (!sub) begin
              sub_nxt = 1'b1;
            end else begin
              sub_nxt       = 1'b0;
              frame_cnt_nxt = (frame_cnt == 8'd191) ? 8'd0 : frame_cnt + 8'd1;
              if (en) begin
                latch = 1'b1;
              end else begin
                state_nxt     = IDLE;
                frame_cnt_nxt = '0;
              end
            end
          end else begin
            hc_nxt = hc + 6'd1;
            if (hc == 6'd7) state_nxt = PAYLOAD;
          end
        end
      endcase

      if (state_nxt == PREAMBLE && hc_nxt == 6'd0) begin
        pre_pat_nxt = (sub_nxt ? PRE_W : (frame_cnt_nxt == 8'd0 ? PRE_B : PRE_M))
                      ^ {8{spdif_out}};
        out_nxt     = pre_pat_nxt[7];
      end else if (state_nxt == PREAMBLE) begin
        out_nxt = pre_pat[3'd7 - hc_nxt[2:0]];
      end else if (state_nxt == PAYLOAD) begin
        // Biphase mark: transition at every cell start, mid-cell transition for a 1.
        out_nxt = hc_nxt[0] ? (spdif_out ^ slot_bit) : ~spdif_out;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      hc          <= '0;
      sub         <= 1'b0;
      frame_cnt   <= '0;
      pre_pat     <= '0;
      spdif_out   <= 1'b0;
      sample_req  <= 1'b0;
      block_start <= 1'b0;
      hold_left   <= '0;
      hold_right  <= '0;
      hold_valid  <= 1'b0;
      hold_rate   <= '0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= strobe ? '0 : div_cnt + 1'b1;
      hc          <= hc_nxt;
      sub         <= sub_nxt;
      frame_cnt   <= frame_cnt_nxt;
      pre_pat     <= pre_pat_nxt;
      spdif_out   <= out_nxt;
      sample_req  <= latch;
      block_start <= latch && (frame_cnt_nxt == 8'd0);
      if (latch) begin
        hold_left  <= data_left[31:8];
        hold_right <= data_right[31:8];
        hold_valid <= validity;
        hold_rate  <= sample_rate_code;
      end
    end
  end

endmodule
